// File: rtl/tty_pkg.sv
// tty_pkg: shared constants, state encoding and cell packing for the glass-TTY sequencer.
package tty_pkg;
    localparam int COLS     = 128;
    localparam int ROWS     = 32;
    localparam int BUF_ROWS = 64;

    localparam logic [5:0] REG_SCROLLV = 6'd0;
    localparam logic [5:0] REG_XCURSOR = 6'd2;
    localparam logic [5:0] REG_YCURSOR = 6'd3;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    localparam logic [6:0] ATTR_INIT = 7'h07;

    typedef enum logic [2:0] {
        INIT_CLR, IDLE, PUTC, CLR_ROW, CLR_ALL, SET_SCROLL, SET_X, SET_Y
    } state_t;

    function automatic logic [15:0] cell_pack(input logic [6:0] a, input logic [7:0] ch);
        return {1'b0, a[6:4], a[3:0], ch};
    endfunction

    function automatic logic [14:0] reg_addr(input logic [5:0] idx);
        return {2'b10, 4'b0000, idx, 3'b000};
    endfunction
endpackage

// File: rtl/tty_clear_seq.sv
// tty_clear_seq: word-address counter for clearing one buffer row or the whole buffer.
module tty_clear_seq
    import tty_pkg::*;
(
    input  logic        clk_data,
    input  logic        irstn,
    input  logic        i_start,
    input  logic        i_step,
    input  logic        i_full,
    input  logic [5:0]  i_row,
    output logic [14:0] o_addr,
    output logic        o_done
);
    logic [10:0] r_cnt;

    // The counter self-clears on its last word so the next clear always begins at zero.
    assign o_done = i_full ? (r_cnt == 11'(BUF_ROWS * 32 - 1)) : (&r_cnt[4:0]);
    assign o_addr = {1'b0, i_full ? r_cnt[10:5] : i_row, r_cnt[4:0], 3'b000};

    always_ff @(posedge clk_data or negedge irstn) begin
        if (!irstn)
            r_cnt <= '0;
        else
            r_cnt <= (i_start || (i_step && o_done)) ? '0 : i_step ? r_cnt + 11'd1 : r_cnt;
    end
endmodule

// File: rtl/tty_console_ctrl.sv
// tty_console_ctrl: turns a console byte stream into frame-store cell, clear and cursor/scroll writes.
module tty_console_ctrl
    import tty_pkg::*;
(
    input  logic        clk_data,
    input  logic        irstn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  attr,
    output logic        busy,
    output logic [14:0] addrb,
    output logic [63:0] dinb,
    output logic [7:0]  web,
    output logic        enb
);
    state_t      r_state, w_next;
    logic [6:0]  r_col, w_col;
    logic [4:0]  r_line, w_line;
    logic [5:0]  r_top, w_top;
    logic [7:0]  r_ch;
    logic [6:0]  r_attr;
    logic [14:0] w_addr, w_clr_addr;
    logic [63:0] w_din;
    logic [7:0]  w_we;
    logic        w_en, w_start, w_accept, w_clr_done, w_bottom;
    logic [5:0]  w_abs_row;
    logic [4:0]  w_nl_line;
    logic [5:0]  w_nl_top;
    state_t      w_nl_next;

    assign in_ready  = r_state == IDLE;
    assign busy      = !in_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_abs_row = r_top + 6'(r_line);
    assign w_bottom  = r_line == 5'(ROWS - 1);
    // Newline at the bottom line scrolls: bump top and clear the row that becomes visible.
    assign w_nl_line = w_bottom ? r_line : r_line + 5'd1;
    assign w_nl_top  = w_bottom ? r_top + 6'd1 : r_top;
    assign w_nl_next = w_bottom ? CLR_ROW : SET_X;

    tty_clear_seq u_clr (
        .clk_data (clk_data),
        .irstn    (irstn),
        .i_start  (w_start),
        .i_step   (r_state == INIT_CLR || r_state == CLR_ROW || r_state == CLR_ALL),
        .i_full   (r_state != CLR_ROW),
        .i_row    (r_top + 6'(ROWS - 1)),
        .o_addr   (w_clr_addr),
        .o_done   (w_clr_done)
    );

    always_comb begin
        w_next  = r_state;
        w_col   = r_col;
        w_line  = r_line;
        w_top   = r_top;
        w_start = 1'b0;
        w_en    = 1'b0;
        w_we    = 8'h00;
        w_addr  = addrb;
        w_din   = dinb;
        case (r_state)
            INIT_CLR, CLR_ROW, CLR_ALL: begin
                w_en   = 1'b1;
                w_we   = 8'hFF;
                w_addr = w_clr_addr;
                w_din  = {4{cell_pack(r_attr, CH_SP)}};
                if (w_clr_done) begin
                    w_next = SET_SCROLL;
                    if (r_state == CLR_ALL) begin
                        w_col  = '0;
                        w_line = '0;
                        w_top  = '0;
                    end
                end
            end
            IDLE: if (w_accept) begin
                if (in_data inside {[CH_SP:CH_TILDE]})
                    w_next = PUTC;
                else if (in_data == CH_LF) begin
                    w_next  = w_nl_next;
                    w_line  = w_nl_line;
                    w_top   = w_nl_top;
                    w_start = w_bottom;
                end else if (in_data == CH_CR) begin
                    w_col  = '0;
                    w_next = SET_X;
                end else if (in_data == CH_BS) begin
                    w_col  = |r_col ? r_col - 7'd1 : r_col;
                    w_next = SET_X;
                end else if (in_data == CH_FF) begin
                    w_next  = CLR_ALL;
                    w_start = 1'b1;
                end
            end
            PUTC: begin
                w_en   = 1'b1;
                w_we   = 8'b11 << {r_col[1:0], 1'b0};
                w_addr = {1'b0, w_abs_row, r_col[6:2], 3'b000};
                w_din  = {4{cell_pack(r_attr, r_ch)}};
                if (r_col == 7'(COLS - 1)) begin
                    w_col   = '0;
                    w_next  = w_nl_next;
                    w_line  = w_nl_line;
                    w_top   = w_nl_top;
                    w_start = w_bottom;
                end else begin
                    w_col  = r_col + 7'd1;
                    w_next = SET_X;
                end
            end
            SET_SCROLL: begin
                w_en   = 1'b1;
                w_we   = 8'hFF;
                w_addr = reg_addr(REG_SCROLLV);
                w_din  = 64'({1'b0, r_top});
                w_next = SET_X;
            end
            SET_X: begin
                w_en   = 1'b1;
                w_we   = 8'hFF;
                w_addr = reg_addr(REG_XCURSOR);
                w_din  = 64'(r_col);
                w_next = SET_Y;
            end
            SET_Y: begin
                w_en   = 1'b1;
                w_we   = 8'hFF;
                w_addr = reg_addr(REG_YCURSOR);
                w_din  = 64'({1'b0, w_abs_row});
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_data or negedge irstn) begin
        if (!irstn) begin
            r_state <= INIT_CLR;
            r_col   <= '0;
            r_line  <= '0;
            r_top   <= '0;
            r_ch    <= '0;
            r_attr  <= ATTR_INIT;
            addrb   <= '0;
            dinb    <= '0;
            web     <= '0;
            enb     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_col   <= w_col;
            r_line  <= w_line;
            r_top   <= w_top;
            addrb   <= w_addr;
            dinb    <= w_din;
            web     <= w_we;
            enb     <= w_en;
            if (w_accept) begin
                r_ch   <= in_data;
                r_attr <= attr;
            end
        end
    end
endmodule

// File: tb/tb_tty_console_ctrl.sv
// tb_tty_console_ctrl: scoreboarded, table-driven bench for the glass-TTY sequencer.
module tb_tty_console_ctrl;
    logic        clk_data = 1'b0;
    logic        irstn    = 1'b0;
    logic [7:0]  in_data  = '0;
    logic        in_valid = 1'b0;
    logic [6:0]  attr     = '0;
    logic        in_ready, busy, enb;
    logic [14:0] addrb;
    logic [63:0] dinb;
    logic [7:0]  web;

    tty_console_ctrl dut (
        .clk_data (clk_data),
        .irstn    (irstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .attr     (attr),
        .busy     (busy),
        .addrb    (addrb),
        .dinb     (dinb),
        .web      (web),
        .enb      (enb)
    );

    always #5 clk_data = ~clk_data;

    typedef struct packed { logic [14:0] a; logic [63:0] d; logic [7:0] w; } wr_t;
    typedef struct { logic [7:0] ch; logic [6:0] at; int gap; int nw; logic [7:0] fw; logic [6:0] x; logic [6:0] y; } vec_t;

    wr_t        q[$];
    wr_t        log_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_col, m_line, m_top;
    logic [6:0] l_x, l_y, l_s;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] quad(input logic [6:0] at, input logic [7:0] ch);
        return {4{1'b0, at, ch}};
    endfunction

    task automatic push(input int a, input logic [63:0] d, input logic [7:0] w);
        q.push_back({15'(a), d, w});
    endtask

    task automatic push_regs(input bit scroll);
        if (scroll) push(16384, 64'(m_top), 8'hFF);
        push(16384 + 16, 64'(m_col), 8'hFF);
        push(16384 + 24, 64'((m_top + m_line) % 64), 8'hFF);
    endtask

    task automatic model_clear_all(input logic [6:0] at);
        for (int i = 0; i < 2048; i++) push(i * 8, quad(at, 8'h20), 8'hFF);
        m_col = 0;
        m_line = 0;
        m_top = 0;
        push_regs(1'b1);
    endtask

    task automatic model_newline(input logic [6:0] at);
        if (m_line < 31) begin
            m_line++;
            push_regs(1'b0);
        end else begin
            m_top = (m_top + 1) % 64;
            for (int c = 0; c < 32; c++) push(((m_top + 31) % 64) * 256 + c * 8, quad(at, 8'h20), 8'hFF);
            push_regs(1'b1);
        end
    endtask

    task automatic model_byte(input logic [7:0] ch, input logic [6:0] at);
        logic [7:0] we;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            we = 8'h03 << (2 * (m_col % 4));
            push(((m_top + m_line) % 64) * 256 + (m_col / 4) * 8, quad(at, ch), we);
            if (m_col == 127) begin
                m_col = 0;
                model_newline(at);
            end else begin
                m_col++;
                push_regs(1'b0);
            end
        end else if (ch == 8'h0A) model_newline(at);
        else if (ch == 8'h0D) begin
            m_col = 0;
            push_regs(1'b0);
        end else if (ch == 8'h08) begin
            if (m_col > 0) m_col--;
            push_regs(1'b0);
        end else if (ch == 8'h0C) model_clear_all(at);
    endtask

    // One clock: sample the write port on the falling edge and score any write.
    task automatic tick();
        wr_t e;
        @(negedge clk_data);
        if (irstn && enb) begin
            log_q.push_back({addrb, dinb, web});
            if (addrb == 15'h4000) l_s = dinb[6:0];
            if (addrb == 15'h4010) l_x = dinb[6:0];
            if (addrb == 15'h4018) l_y = dinb[6:0];
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h web %h, expected no write", addrb, dinb, web);
            end else begin
                e = q.pop_front();
                chk("write", {addrb, dinb, web}, e);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && q.size() == 0) && n < 5000) begin
            tick();
            n++;
        end
        chk("drain", 128'(n < 5000), 128'(1));
    endtask

    task automatic xfer(input logic [7:0] ch, input logic [6:0] at, output int gap);
        int n = 0;
        model_byte(ch, at);
        in_data = ch;
        attr = at;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
        gap = n + 1;
        wait_idle();
    endtask

    task automatic boot(input string nm);
        int n = 0;
        irstn = 1'b1;
        while (!in_ready && n < 3000) begin
            tick();
            n++;
        end
        chk(nm, 128'(n), 128'(2051));
        wait_idle();
    endtask

    initial begin
        vec_t tv[16];
        int   gap, base, n;
        tv[0]  = '{8'h48, 7'h07, 4, 3, 8'h03, 7'd1, 7'd0};
        tv[1]  = '{8'h45, 7'h07, 4, 3, 8'h0C, 7'd2, 7'd0};
        tv[2]  = '{8'h4C, 7'h07, 4, 3, 8'h30, 7'd3, 7'd0};
        tv[3]  = '{8'h4C, 7'h07, 4, 3, 8'hC0, 7'd4, 7'd0};
        tv[4]  = '{8'h4F, 7'h07, 4, 3, 8'h03, 7'd5, 7'd0};
        tv[5]  = '{8'h41, 7'h1E, 4, 3, 8'h0C, 7'd6, 7'd0};
        tv[6]  = '{8'h08, 7'h07, 3, 2, 8'hFF, 7'd5, 7'd0};
        tv[7]  = '{8'h01, 7'h07, 1, 0, 8'h00, 7'd5, 7'd0};
        tv[8]  = '{8'hFF, 7'h07, 1, 0, 8'h00, 7'd5, 7'd0};
        tv[9]  = '{8'h0D, 7'h07, 3, 2, 8'hFF, 7'd0, 7'd0};
        tv[10] = '{8'h08, 7'h07, 3, 2, 8'hFF, 7'd0, 7'd0};
        tv[11] = '{8'h0A, 7'h07, 3, 2, 8'hFF, 7'd0, 7'd1};
        tv[12] = '{8'h7E, 7'h5A, 4, 3, 8'h03, 7'd1, 7'd1};
        tv[13] = '{8'h7F, 7'h07, 1, 0, 8'h00, 7'd1, 7'd1};
        tv[14] = '{8'h0D, 7'h07, 3, 2, 8'hFF, 7'd0, 7'd1};
        tv[15] = '{8'h1F, 7'h07, 1, 0, 8'h00, 7'd0, 7'd1};

        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_enb", enb, 0);
        chk("rst_web", web, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_dinb", dinb, 0);
        model_clear_all(7'h07);
        tick();
        tick();
        base = log_q.size();
        boot("init_cycles");
        chk("init_writes", log_q.size() - base, 2051);
        chk("busy_idle", busy, 0);

        for (int i = 0; i < 16; i++) begin
            base = log_q.size();
            xfer(tv[i].ch, tv[i].at, gap);
            chk($sformatf("v%0d_gap", i), gap, tv[i].gap);
            chk($sformatf("v%0d_nwrites", i), log_q.size() - base, tv[i].nw);
            chk($sformatf("v%0d_first_web", i), (log_q.size() > base) ? log_q[base].w : 8'h00, tv[i].fw);
            chk($sformatf("v%0d_xcursor", i), l_x, tv[i].x);
            chk($sformatf("v%0d_ycursor", i), l_y, tv[i].y);
        end

        for (int i = 0; i < 128; i++) begin
            base = log_q.size();
            xfer(8'(32 + i % 95), 7'h34, gap);
        end
        chk("wrap_nwrites", log_q.size() - base, 3);
        chk("wrap_last_web", log_q[base].w, 8'hC0);
        chk("wrap_last_addr", log_q[base].a, 15'h01F8);
        chk("wrap_xcursor", l_x, 0);
        chk("wrap_ycursor", l_y, 2);

        base = log_q.size();
        xfer(8'h0C, 7'h2A, gap);
        chk("ff_writes", log_q.size() - base, 2051);
        chk("ff_scrollv", l_s, 0);
        chk("ff_xcursor", l_x, 0);
        chk("ff_ycursor", l_y, 0);

        for (int i = 0; i < 32; i++) begin
            base = log_q.size();
            xfer(8'h0A, 7'h07, gap);
        end
        chk("scroll_writes", log_q.size() - base, 35);
        chk("scroll_row_first", log_q[base].a, 15'h2000);
        chk("scroll_row_last", log_q[base + 31].a, 15'h20F8);
        chk("scroll_scrollv", l_s, 1);
        chk("scroll_ycursor", l_y, 32);

        for (int i = 0; i < 63; i++) begin
            base = log_q.size();
            xfer(8'h0A, 7'h07, gap);
        end
        chk("topwrap_scrollv", l_s, 0);
        chk("topwrap_row_first", log_q[base].a, 15'h1F00);
        chk("topwrap_ycursor", l_y, 31);

        base = log_q.size();
        model_byte(8'h0C, 7'h2A);
        in_data = 8'h0C;
        attr = 7'h2A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (log_q.size() - base < 700 && n < 3000) begin
            tick();
            n++;
        end
        chk("mid_clear_words", log_q.size() - base, 700);
        #2 irstn = 1'b0;
        #1;
        chk("async_enb", enb, 0);
        chk("async_web", web, 0);
        chk("async_busy", busy, 1);
        chk("async_in_ready", in_ready, 0);
        q.delete();
        model_clear_all(7'h07);
        tick();
        tick();
        base = log_q.size();
        boot("reinit_cycles");
        chk("reinit_first_addr", log_q[base].a, 0);
        chk("reinit_writes", log_q.size() - base, 2051);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
